add_group_scheduler: RTL and testbench
======================================

// Module: add_group_scheduler
// PURPOSE
//  Time-shares one registered 3-input adder across NUM_GRP channel groups
//  (each group = 3 input channels). It replaces NUM_GRP parallel 3-layer
//  adders, e.g. 96->32 channel reduction with one adder.
//  Handshakes are valid/ready on both sides. Arbitration is round-robin.
//  Each group's pixels are counted per frame. frame_done pulses once every
//  group has delivered D*D sums.
// PARAMETERS
//  D           220  feature-map side; each group supplies D*D pixel triples per frame
//  DATA_WIDTH  32   pixel width (two's complement)
//  NUM_GRP     32   number of requesting groups; GW = $clog2(NUM_GRP), minimum 1
// PORTS
//  clk        in   1                     clock, all logic on rising edge
//  reset      in   1                     synchronous active-low reset
//  start      in   1                     1-cycle pulse, begins a frame (sampled in IDLE only)
//  req_valid  in   NUM_GRP               group g has a pixel triple pending
//  req_pxl    in   NUM_GRP*3*DATA_WIDTH  triple of group g; channel k of g at bits [(3g+k)*DATA_WIDTH +: DATA_WIDTH]
//  req_ready  out  NUM_GRP               one-hot grant; triple taken when req_valid[g] & req_ready[g]
//  out_valid  out  1                     out_pxl/out_grp valid
//  out_ready  in   1                     downstream accepts when out_valid & out_ready
//  out_pxl    out  DATA_WIDTH            sum of the 3 channels
//  out_grp    out  GW                    group index of out_pxl
//  busy       out  1                     state != IDLE
//  frame_done out  1                     1-cycle pulse at end of frame
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE; out_valid=0, out_pxl=0, out_grp=0,
//    req_ready=0, frame_done=0. RR pointer=0. All group counters=0, done mask=0.
//    Reset overrides everything, including mid-frame; a partial frame is discarded.
//  - FSM IDLE -> RUN on start.
//  - FSM RUN -> FLUSH when done mask is all ones.
//  - FSM FLUSH -> DONE when out_valid==0, or out_valid&out_ready in that cycle.
//  - FSM DONE -> IDLE after one cycle. frame_done=1 only in DONE.
//    Counters and done mask are cleared on DONE->IDLE.
//  - Eligible[g] = req_valid[g] & ~done[g].
//  - Output slot free = ~out_valid | out_ready.
//  - req_ready is combinational. It is asserted only in RUN with slot free, for the
//    first eligible g scanning ptr, ptr+1, ... mod NUM_GRP. Otherwise req_ready=0.
//  - On grant to g:
//    * next cycle out_valid=1, out_pxl = (c0+c1+c2) mod 2^DATA_WIDTH (wraps, no
//      saturation), out_grp=g. Latency is 1 cycle.
//    * ptr <= (g+1) mod NUM_GRP.
//    * cnt[g]++. When cnt[g] reaches D*D-1 and is granted, done[g]<=1; cnt[g] holds.
//  - No grant and out_ready=1: out_valid<=0. Output fields hold while out_valid & ~out_ready.
//  - Simultaneous out accept and new grant: the register loads the new sum, with
//    no bubble. Full throughput is 1 sum/cycle.
//  - Fairness: a continuously valid group is granted within NUM_GRP grants.
//  - Groups in done mask are never granted, even if req_valid=1. Downstream
//    receives exactly NUM_GRP*D*D sums per frame.
//  - start outside IDLE is ignored. Counter width = $clog2(D*D+1).
// TESTING (bench params D=2, DATA_WIDTH=8, NUM_GRP=4)
//  1 Reset mid-RUN: after 3 grants assert reset=0 for 1 cycle.
//    -> all outputs 0, state IDLE; next frame needs 16 fresh sums before frame_done.
//  2 Single group: only grp2 valid, triple (10,20,30), out_ready=1.
//    -> out_pxl=60, out_grp=2 one cycle after grant; exactly 4 grants, then req_ready[2] stays 0.
//  3 All valid, out_ready=1.
//    -> grant order 0,1,2,3,0,...; 16 sums back-to-back; frame_done pulses once,
//       2 cycles after the last accept (FLUSH, DONE); then IDLE.
//  4 Wraparound: triple (200,100,1).
//    -> out_pxl=45 (301 mod 256).
//  5 Backpressure: out_ready=0 for 5 cycles with out_valid=1.
//    -> out_pxl/out_grp stable, req_ready=0.
//    Release -> new grant in the same cycle as accept; no data loss or duplication.
//  6 start pulsed during RUN -> ignored; frame sum count still 16.

Source files
------------

// File: rtl/add_group_scheduler.sv
// rtl/add_group_scheduler.sv - round-robin time-shared 3-input adder over NUM_GRP channel groups
// One registered adder serves every group; per-group pixel counters mark a group done after D*D sums.
module add_group_scheduler #(
   parameter int D          = 220,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_GRP    = 32,
   localparam int GW        = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [NUM_GRP-1:0]              req_valid,
   input  logic [NUM_GRP*3*DATA_WIDTH-1:0] req_pxl,
   output logic [NUM_GRP-1:0]              req_ready,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DATA_WIDTH-1:0]           out_pxl,
   output logic [GW-1:0]                   out_grp,
   output logic                            busy,
   output logic                            frame_done
);
   localparam int CW = $clog2(D*D+1);
   localparam logic [CW-1:0] LAST_CNT = CW'(D*D-1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [GW-1:0]         ptr_q, ptr_d;
   logic [NUM_GRP-1:0]    done_q, done_d;
   logic [CW-1:0]         cnt_q [NUM_GRP];
   logic [CW-1:0]         cnt_d [NUM_GRP];
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_pxl_q, out_pxl_d;
   logic [GW-1:0]         out_grp_q, out_grp_d;

   logic [NUM_GRP-1:0]      eligible;
   logic                    slot_free;
   logic                    grant_any;
   logic [GW-1:0]           grant_idx;
   logic [GW-1:0]           cand;
   logic [3*DATA_WIDTH-1:0] sel_trip;
   logic [DATA_WIDTH-1:0]   sum;

   assign eligible  = req_valid & ~done_q;
   assign slot_free = ~out_valid_q | out_ready;

   // First eligible group scanning from the round-robin pointer wins.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      if (state_q == S_RUN && slot_free) begin
         for (int i = 0; i < NUM_GRP; i++) begin
            cand = GW'((int'(ptr_q) + i) % NUM_GRP);
            if (!grant_any && eligible[cand]) begin
               grant_any = 1'b1;
               grant_idx = cand;
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (grant_any) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      sel_trip = '0;
      for (int g = 0; g < NUM_GRP; g++) begin
         if (grant_idx == GW'(g)) begin
            sel_trip = req_pxl[3*g*DATA_WIDTH +: 3*DATA_WIDTH];
         end
      end
      sum = sel_trip[0 +: DATA_WIDTH] + sel_trip[DATA_WIDTH +: DATA_WIDTH]
          + sel_trip[2*DATA_WIDTH +: DATA_WIDTH];
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      done_d      = done_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_pxl_d   = out_pxl_q;
      out_grp_d   = out_grp_q;

      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (&done_q) state_d = S_FLUSH;
         S_FLUSH: if (!out_valid_q || out_ready) state_d = S_DONE;
         S_DONE: begin
            state_d = S_IDLE;
            done_d  = '0;
            for (int i = 0; i < NUM_GRP; i++) begin
               cnt_d[i] = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A grant reloads the output register even while it is being drained, so no bubble.
      if (grant_any) begin
         out_valid_d = 1'b1;
         out_pxl_d   = sum;
         out_grp_d   = grant_idx;
         ptr_d       = (grant_idx == GW'(NUM_GRP-1)) ? '0 : grant_idx + 1'b1;
         cnt_d[grant_idx] = cnt_q[grant_idx] + 1'b1;
         if (cnt_q[grant_idx] == LAST_CNT) begin
            done_d[grant_idx] = 1'b1;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         done_q      <= '0;
         out_valid_q <= 1'b0;
         out_pxl_q   <= '0;
         out_grp_q   <= '0;
         for (int i = 0; i < NUM_GRP; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         out_pxl_q   <= out_pxl_d;
         out_grp_q   <= out_grp_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_pxl    = out_pxl_q;
   assign out_grp    = out_grp_q;
   assign busy       = (state_q != S_IDLE);
   assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_add_group_scheduler.sv
// tb/tb_add_group_scheduler.sv - directed self-checking bench for add_group_scheduler
// Vector table walks a whole frame one group at a time; hand sequences cover reset, RR order and backpressure.
module tb_add_group_scheduler;
   localparam int D  = 2;
   localparam int DW = 8;
   localparam int NG = 4;
   localparam int GW = 2;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               start = 1'b0;
   logic [NG-1:0]      req_valid = '0;
   logic [NG*3*DW-1:0] req_pxl = '0;
   logic [NG-1:0]      req_ready;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [DW-1:0]      out_pxl;
   logic [GW-1:0]      out_grp;
   logic               busy;
   logic               frame_done;

   add_group_scheduler #(.D(D), .DATA_WIDTH(DW), .NUM_GRP(NG)) dut (
      .clk(clk), .reset(reset), .start(start), .req_valid(req_valid), .req_pxl(req_pxl),
      .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready), .out_pxl(out_pxl),
      .out_grp(out_grp), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_grp [NG];

   typedef struct {
      int           g;
      logic [DW-1:0] c0, c1, c2;
      logic [DW-1:0] exp;
      bit           gnt;
   } vec_t;
   vec_t tbl [17];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [NG-1:0] v);
      if ($countones(v) != 1) return -1;
      for (int i = 0; i < NG; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic set_group(input int g, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] c);
      req_pxl[(3*g+0)*DW +: DW] = a;
      req_pxl[(3*g+1)*DW +: DW] = b;
      req_pxl[(3*g+2)*DW +: DW] = c;
   endtask

   task automatic setup_all();
      for (int g = 0; g < NG; g++) begin
         set_group(g, DW'(g+1), DW'(2*(g+1)), DW'(3));
         exp_grp[g] = DW'(3*g+6);
      end
      req_valid = '1;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset = 1'b0; start = 1'b0; req_valid = '0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run_frame(input int bp_at, input int start_at, input bit chk_order,
                            output int nsums, output int ndone, output int gap);
      int ngr = 0;
      int last_acc = -1;
      int done_cyc = -1;
      int gcnt [NG];
      logic [DW-1:0] hp = '0;
      logic [GW-1:0] hg = '0;
      nsums = 0; ndone = 0;
      foreach (gcnt[i]) gcnt[i] = 0;
      for (int cyc = 0; cyc < 120; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= bp_at && cyc < bp_at + 5);
         start = (cyc == start_at);
         #1;
         if (cyc == bp_at) begin
            hp = out_pxl; hg = out_grp;
            chk("bp_valid", int'(out_valid), 1);
         end
         if (cyc >= bp_at && cyc < bp_at + 5) begin
            chk("bp_ready", int'(req_ready), 0);
            chk("bp_pxl", int'(out_pxl), int'(hp));
            chk("bp_grp", int'(out_grp), int'(hg));
         end
         if (cyc == bp_at + 5) chk("bp_release_grant", int'(req_ready != 0), 1);
         if (req_ready != 0) begin
            if (chk_order) chk("grant_order", onehot_idx(req_ready), ngr % NG);
            ngr++;
         end
         if (out_valid && out_ready) begin
            nsums++;
            gcnt[out_grp]++;
            chk("sum", int'(out_pxl), int'(exp_grp[out_grp]));
            last_acc = cyc;
         end
         if (frame_done) begin
            ndone++;
            done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      end
      gap = done_cyc - last_acc;
      for (int g = 0; g < NG; g++) chk("grp_count", gcnt[g], D*D);
      start = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int ns, nd, gap, ng;
      bit prev, seen;
      logic [NG-1:0] exp_rdy;

      tbl[0]  = '{0, 8'd1,   8'd2,   8'd3,   8'd6,   1'b1};
      tbl[1]  = '{1, 8'd10,  8'd20,  8'd30,  8'd60,  1'b1};
      tbl[2]  = '{2, 8'd200, 8'd100, 8'd1,   8'd45,  1'b1};
      tbl[3]  = '{3, 8'd255, 8'd255, 8'd255, 8'd253, 1'b1};
      tbl[4]  = '{0, 8'd128, 8'd128, 8'd0,   8'd0,   1'b1};
      tbl[5]  = '{1, 8'd0,   8'd0,   8'd0,   8'd0,   1'b1};
      tbl[6]  = '{2, 8'd127, 8'd1,   8'd0,   8'd128, 1'b1};
      tbl[7]  = '{3, 8'd100, 8'd100, 8'd100, 8'd44,  1'b1};
      tbl[8]  = '{0, 8'd255, 8'd1,   8'd0,   8'd0,   1'b1};
      tbl[9]  = '{1, 8'd5,   8'd6,   8'd7,   8'd18,  1'b1};
      tbl[10] = '{2, 8'd250, 8'd3,   8'd2,   8'd255, 1'b1};
      tbl[11] = '{3, 8'd50,  8'd60,  8'd70,  8'd180, 1'b1};
      tbl[12] = '{0, 8'd9,   8'd9,   8'd9,   8'd27,  1'b1};
      tbl[13] = '{0, 8'd1,   8'd1,   8'd1,   8'd3,   1'b0};
      tbl[14] = '{1, 8'd17,  8'd34,  8'd51,  8'd102, 1'b1};
      tbl[15] = '{2, 8'd255, 8'd255, 8'd2,   8'd0,   1'b1};
      tbl[16] = '{3, 8'd64,  8'd64,  8'd64,  8'd192, 1'b1};

      // reset state
      req_valid = '1;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_pxl", int'(out_pxl), 0);
      chk("rst_out_grp", int'(out_grp), 0);
      chk("rst_req_ready", int'(req_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      reset = 1'b1;

      // vector table: one group at a time, each group 4 grants, one request from a done group
      reset_dut();
      out_ready = 1'b1;
      do_start();
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         if (i > 0) begin
            if (tbl[i-1].gnt) begin
               chk("tbl_out_valid", int'(out_valid), 1);
               chk("tbl_out_pxl", int'(out_pxl), int'(tbl[i-1].exp));
               chk("tbl_out_grp", int'(out_grp), tbl[i-1].g);
            end else begin
               chk("tbl_idle_valid", int'(out_valid), 0);
            end
         end
         req_valid = '0;
         req_valid[tbl[i].g] = 1'b1;
         set_group(tbl[i].g, tbl[i].c0, tbl[i].c1, tbl[i].c2);
         exp_rdy = '0;
         if (tbl[i].gnt) exp_rdy[tbl[i].g] = 1'b1;
         #1 chk("tbl_req_ready", int'(req_ready), int'(exp_rdy));
      end
      @(negedge clk);
      chk("tbl_last_pxl", int'(out_pxl), int'(tbl[16].exp));
      chk("tbl_last_grp", int'(out_grp), tbl[16].g);
      req_valid = '0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
         if (frame_done) seen = 1;
      end
      chk("tbl_frame_done", int'(seen), 1);
      chk("tbl_idle_after", int'(busy), 0);

      // reset mid-RUN discards the partial frame
      reset_dut();
      setup_all();
      out_ready = 1'b1;
      do_start();
      ng = 0;
      for (int c = 0; c < 20 && ng < 3; c++) begin
         @(negedge clk); #1;
         if (req_ready != 0) ng++;
      end
      chk("t1_grants", ng, 3);
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      #1;
      chk("t1_out_valid", int'(out_valid), 0);
      chk("t1_out_pxl", int'(out_pxl), 0);
      chk("t1_out_grp", int'(out_grp), 0);
      chk("t1_req_ready", int'(req_ready), 0);
      chk("t1_busy", int'(busy), 0);
      do_start();
      run_frame(-100, -100, 1'b0, ns, nd, gap);
      chk("t1_sums", ns, NG*D*D);
      chk("t1_done_pulses", nd, 1);

      // single group: grp2 only
      reset_dut();
      req_valid = 4'b0100;
      set_group(2, 8'd10, 8'd20, 8'd30);
      out_ready = 1'b1;
      do_start();
      ng = 0; prev = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk); #1;
         if (prev) begin
            chk("t2_out_valid", int'(out_valid), 1);
            chk("t2_out_pxl", int'(out_pxl), 60);
            chk("t2_out_grp", int'(out_grp), 2);
         end
         prev = (req_ready != 0);
         if (prev) begin
            chk("t2_req_ready", int'(req_ready), 4);
            ng++;
         end
      end
      chk("t2_grants", ng, D*D);
      chk("t2_ready_low", int'(req_ready), 0);
      chk("t2_still_busy", int'(busy), 1);

      // all valid: round-robin order, back-to-back, frame_done 2 cycles after last accept
      reset_dut();
      setup_all();
      out_ready = 1'b1;
      do_start();
      run_frame(-100, -100, 1'b1, ns, nd, gap);
      chk("t3_sums", ns, NG*D*D);
      chk("t3_done_pulses", nd, 1);
      chk("t3_done_gap", gap, 2);
      chk("t3_idle", int'(busy), 0);

      // backpressure for 5 cycles plus a start pulse during RUN
      reset_dut();
      setup_all();
      out_ready = 1'b1;
      do_start();
      run_frame(3, 5, 1'b0, ns, nd, gap);
      chk("t5_sums", ns, NG*D*D);
      chk("t5_done_pulses", nd, 1);
      chk("t5_idle", int'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
